pulse_handshake_tx: RTL

Transmit end of the pulse crossing path: accepts single-cycle event pulses in the `clk_dst` system domain, queues them in a pending counter, and delivers each one to a foreign clock domain over a 4-phase level handshake (`req_out` / `ack_async`). It is the counterpart to the receive-side pulse synchronizer. It carries vending-machine events, such as vend-complete and change-due, back to the coin/display logic without loss, even when pulses arrive faster than the far domain can consume them.

---
 rtl/pulse_handshake_tx.sv | 95 +++++++++
 1 files changed

// File: rtl/pulse_handshake_tx.sv
// pulse_handshake_tx: queues clk_dst event pulses and delivers each over a 4-phase req/ack handshake.
// Optional request timeout is compiled in with the macro PULSE_HANDSHAKE_TX_TIMEOUT_EN.
module pulse_handshake_tx #(
   parameter int CNT_W   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic             clk_dst,
   input  logic             rstn,
   input  logic             pulse_in,
   input  logic             ack_async,
   input  logic             err_clr,
   output logic             req_out,
   output logic             busy,
   output logic [CNT_W-1:0] pending,
   output logic             done_pulse,
   output logic             overflow,
   output logic             timeout_err
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT_LOW} state_t;
   localparam logic [CNT_W-1:0] FULL = '1;
   state_t state, state_d;
   logic ack_m, ack_s, launch, req_d, done_d, abort, ovf_set;
   // two-flop synchronizer for the far-domain acknowledge level
   always_ff @(posedge clk_dst or negedge rstn)
      if (!rstn) begin
         ack_m <= 1'b0;
         ack_s <= 1'b0;
      end else begin
         ack_m <= ack_async;
         ack_s <= ack_m;
      end
`ifdef PULSE_HANDSHAKE_TX_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT);
   logic [TW-1:0] tcnt;
   // cycles spent in REQ, restarted on every launch
   always_ff @(posedge clk_dst or negedge rstn)
      if (!rstn) tcnt <= '0;
      else if (launch) tcnt <= '0;
      else if (state == REQ) tcnt <= tcnt + 1'b1;
   assign abort = (state == REQ) && !ack_s && (tcnt == TW'(TIMEOUT - 1));
   // sticky timeout flag; a fresh abort beats a simultaneous clear
   always_ff @(posedge clk_dst or negedge rstn)
      if (!rstn) timeout_err <= 1'b0;
      else timeout_err <= abort | (timeout_err & ~err_clr);
`else
   assign abort       = 1'b0;
   assign timeout_err = 1'b0;
`endif
   // next state, launch decision and next values of the registered outputs
   always_comb begin
      state_d = state;
      req_d   = req_out;
      done_d  = 1'b0;
      launch  = 1'b0;
      case (state)
         IDLE:     if (pending != '0) begin
                      launch  = 1'b1;
                      req_d   = 1'b1;
                      state_d = REQ;
                   end
         REQ:      if (ack_s || abort) begin
                      req_d   = 1'b0;
                      state_d = WAIT_LOW;
                   end
         WAIT_LOW: if (!ack_s) begin
                      done_d  = 1'b1;
                      state_d = IDLE;
                   end
         default:  state_d = IDLE;
      endcase
   end
   // state register and registered handshake outputs
   always_ff @(posedge clk_dst or negedge rstn)
      if (!rstn) begin
         state      <= IDLE;
         req_out    <= 1'b0;
         done_pulse <= 1'b0;
      end else begin
         state      <= state_d;
         req_out    <= req_d;
         done_pulse <= done_d;
      end
   assign ovf_set = pulse_in & ~launch & (pending == FULL);
   // pending counter saturates at FULL; overflow is sticky with set beating clear
   always_ff @(posedge clk_dst or negedge rstn)
      if (!rstn) begin
         pending  <= '0;
         overflow <= 1'b0;
      end else begin
         if (pulse_in & ~launch & ~ovf_set) pending <= pending + 1'b1;
         else if (~pulse_in & launch) pending <= pending - 1'b1;
         overflow <= ovf_set | (overflow & ~err_clr);
      end
   assign busy = (state != IDLE) || (pending != '0);
endmodule
